// File: rtl/i2c_target_regs.sv
// I2C target with a four-byte register bank shared with an Avalon-MM slave port.
// SDA is only ever pulled low through sda_oe; the pad is open-drain at the top level.
module i2c_target_regs #(
  parameter logic [6:0] DEVICE_ADDR = 7'h42
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        i2c_wr_pulse,
  output logic        busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
  } state_t;

  // [0],[1] synchronizer stages, [2] previous value for edge detection
  logic [2:0]  scl_sync_q, sda_sync_q;
  logic        scl_s, scl_p, sda_s, sda_p;
  logic        scl_rise, scl_fall, start_c, stop_c;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [1:0]  ptr_q, ptr_d, ptr_inc;
  logic        oe_q, oe_d;
  logic        busy_q, busy_d;
  logic        commit_q, commit_d;
  logic [7:0]  wbyte_q, wbyte_d;
  logic [7:0]  byte_in;

  logic [7:0]  regs_q [4];
  logic [31:0] readdata_q;
  logic        pulse_q;
  logic        sda_oe_q;
  logic        av_we;
  logic        unused_wdata;

  assign scl_s    = scl_sync_q[1];
  assign scl_p    = scl_sync_q[2];
  assign sda_s    = sda_sync_q[1];
  assign sda_p    = sda_sync_q[2];
  assign scl_rise = scl_s & ~scl_p;
  assign scl_fall = ~scl_s & scl_p;
  assign start_c  = scl_s & scl_p & sda_p & ~sda_s;
  assign stop_c   = scl_s & scl_p & ~sda_p & sda_s;

  assign byte_in      = {shift_q[6:0], sda_s};
  assign ptr_inc      = ptr_q + 2'd1;
  assign av_we        = chipselect & ~write_n;
  assign unused_wdata = ^writedata[31:8];

  assign sda_oe       = sda_oe_q;
  assign readdata     = readdata_q;
  assign i2c_wr_pulse = pulse_q;
  assign busy         = busy_q;

  // Pin synchronizers; idle-high reset value avoids a false START/STOP after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[1:0], scl_in};
      sda_sync_q <= {sda_sync_q[1:0], sda_in};
    end
  end

  // Protocol state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      ptr_q    <= '0;
      oe_q     <= 1'b0;
      busy_q   <= 1'b0;
      commit_q <= 1'b0;
      wbyte_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      ptr_q    <= ptr_d;
      oe_q     <= oe_d;
      busy_q   <= busy_d;
      commit_q <= commit_d;
      wbyte_q  <= wbyte_d;
    end
  end

  // Next-state logic: bits sampled on SCL rise, drive level decided on SCL fall.
  // cnt counts SCL rises across the byte and its ACK slot (8 = ACK pending, 9 = ACK clocked).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    ptr_d    = ptr_q;
    oe_d     = oe_q;
    busy_d   = busy_q;
    commit_d = 1'b0;
    wbyte_d  = wbyte_q;
    if (commit_q) ptr_d = ptr_inc;
    if (start_c) begin
      state_d = ADDR;
      cnt_d   = '0;
      oe_d    = 1'b0;
    end else if (stop_c) begin
      state_d = IDLE;
      cnt_d   = '0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE, WAIT_STOP: ;
        ADDR: if (scl_rise) begin
          shift_d = byte_in;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            if (byte_in[7:1] == DEVICE_ADDR) begin
              state_d = ADDR_ACK;
              busy_d  = 1'b1;
            end else begin
              state_d = WAIT_STOP;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_rise) begin
            cnt_d = 4'd9;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              oe_d = 1'b1;
            end else begin
              cnt_d = '0;
              if (shift_q[0]) begin
                shift_d = regs_q[ptr_q];
                oe_d    = ~regs_q[ptr_q][7];
                state_d = RDATA;
              end else begin
                oe_d    = 1'b0;
                state_d = PTR;
              end
            end
          end
        end
        PTR, WDATA: if (scl_rise) begin
          shift_d = byte_in;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            if (state_q == PTR) begin
              ptr_d   = byte_in[1:0];
              state_d = PTR_ACK;
            end else begin
              commit_d = 1'b1;
              wbyte_d  = byte_in;
              state_d  = WDATA_ACK;
            end
          end
        end
        PTR_ACK, WDATA_ACK: begin
          if (scl_rise) begin
            cnt_d = 4'd9;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              oe_d = 1'b1;
            end else begin
              oe_d    = 1'b0;
              cnt_d   = '0;
              state_d = WDATA;
            end
          end
        end
        RDATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd0) begin
              oe_d = ~shift_q[7];
            end else if (cnt_q == 4'd8) begin
              oe_d    = 1'b0;
              state_d = RDATA_ACK;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
              oe_d    = ~shift_q[6];
            end
          end
        end
        RDATA_ACK: if (scl_rise) begin
          if (!sda_s) begin
            ptr_d   = ptr_inc;
            shift_d = regs_q[ptr_inc];
            cnt_d   = '0;
            state_d = RDATA;
          end else begin
            state_d = WAIT_STOP;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // SDA drive trails the FSM decision by one clk so the pin moves 4 clk after SCL falls.
  always_ff @(posedge clk) begin
    if (reset || stop_c) sda_oe_q <= 1'b0;
    else                 sda_oe_q <= oe_q;
  end

  // Register bank and Avalon read path; an I2C commit beats a same-cycle Avalon write to the same entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 4; i++) regs_q[i] <= '0;
      readdata_q <= '0;
      pulse_q    <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (commit_q && ptr_q == 2'(i))      regs_q[i] <= wbyte_q;
        else if (av_we && address == 2'(i)) regs_q[i] <= writedata[7:0];
      end
      readdata_q <= {24'h0, regs_q[address]};
      pulse_q    <= commit_q;
    end
  end

endmodule

// File: doc/i2c_target_regs.md
# i2c_target_regs

I2C target (responder) with a four-byte register bank shared with an Avalon-MM slave port. It is the far end of the bit-banged SCL/SDA initiator: an external or on-board I2C master reads and writes the bank over the bus, and the Nios side reads and writes the same bank through `s1`. The block drives SDA only by pulling it low through `sda_oe`. The top level maps `sda_oe` to an open-drain pad (`sda = sda_oe ? 0 : Z`).

## Interface
Parameters:
- `DEVICE_ADDR`, default 7'h42: 7-bit I2C target address.

Ports:
- `clk`  in  1: single system clock, 50 MHz; all logic is on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `scl_in`  in  1: raw SCL pin, asynchronous.
- `sda_in`  in  1: raw SDA pin, asynchronous.
- `sda_oe`  out  1: 1 pulls SDA low; 0 releases it.
- `address`  in  2: Avalon register select, 0..3.
- `chipselect`  in  1: Avalon select.
- `write_n`  in  1: Avalon write, active low.
- `writedata`  in  32: only bits [7:0] are used.
- `readdata`  out  32: `{24'b0, reg[address]}`, registered.
- `i2c_wr_pulse`  out  1: one-cycle pulse on every I2C data-byte commit.
- `busy`  out  1: 1 from an address match until STOP.

## Operation
- Synchronizers: `scl_in` and `sda_in` each pass through 2 flops, then a third "previous" flop for edge detection.
- START = synced SDA falls while synced SCL is high. STOP = synced SDA rises while SCL is high.
- Bits are sampled on the SCL rising edge. `sda_oe` changes only on the SCL falling edge.
- The FSM states are IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
- From any state:
  - START goes to ADDR and clears the bit counter (repeated START is supported).
  - STOP goes to IDLE, forces `sda_oe`=0 and `busy`=0.
- ADDR: shift in 8 bits, MSB first.
  - On a match of bits [7:1] with DEVICE_ADDR, go to ADDR_ACK and set `busy`=1.
  - On a mismatch, go to WAIT_STOP and never drive SDA.
- ADDR_ACK: drive the ACK low for one SCL period, then:
  - R/W=0 goes to PTR.
  - R/W=1 loads `reg[ptr]` into the shift register and goes to RDATA.
- PTR: receive 8 bits, set `ptr` = byte[1:0] (bits [7:2] ignored), ACK, then go to WDATA.
- WDATA: on the 8th sampled bit, commit the byte:
  - write `reg[ptr]`, pulse `i2c_wr_pulse`, set `ptr` = `ptr`+1 mod 4 (3 wraps to 0);
  - then ACK and return to WDATA.
- RDATA: drive `sda_oe` = ~shift[7] for each bit, i.e. pull low for 0. Release at the SCL fall after bit 0, then go to RDATA_ACK.
- RDATA_ACK: sample the master's ACK on SCL rise.
  - ACK (SDA=0): set `ptr`+1 mod 4, load the next byte, go to RDATA.
  - NACK: go to WAIT_STOP.
- Avalon side:
  - Write with `chipselect`=1, `write_n`=0 sets `reg[address]` = `writedata[7:0]`.
  - `readdata` updates every clock from `reg[address]`.
  - If an Avalon write and an I2C commit hit the same register in the same cycle, the I2C value wins. Different registers both commit.
- No clock stretching. SCL high and low phases must each last at least 8 clk.

## Timing
- Reset values: `sda_oe`=0, `readdata`=0, `i2c_wr_pulse`=0, `busy`=0, all regs=0, `ptr`=0, state=IDLE.
- Reset asserted mid-transfer releases SDA on the next clk edge.
- START/STOP and edge detection fire 3 clk after the pin transition.
- `sda_oe` changes 4 clk after the SCL pin falls.
- I2C register commit and `i2c_wr_pulse` occur 4 clk after the SCL rise of the 8th data bit.
- The ACK drive starts at the SCL fall after the 8th bit and releases at the following SCL fall.
- Avalon read latency is 1 clk: `readdata` reflects `reg[address]` as of the previous edge.
- An Avalon write is visible on `readdata` 2 clk after the write cycle.

## Test plan
- Address/pointer/data write: START, 0x84, 0x02, 0xA5, 0x3C, STOP → ACK on all four bytes; reg2=0xA5, reg3=0x3C; two `i2c_wr_pulse` pulses; `ptr`=0 (wrap); `busy` drops after STOP.
- Read with repeated START: Avalon writes reg1=0x5A, reg2=0x0F. Then START, 0x84, 0x01, Sr, 0x85, read with ACK, read with NACK, STOP → SDA shows 0x5A then 0x0F; `sda_oe`=0 after NACK.
- Address mismatch: START, 0x90, 0x11 → `sda_oe` stays 0 throughout; regs unchanged; `busy`=0.
- Collision: Avalon write of 0x11 to reg0 in the same clk as the I2C commit of 0x22 to reg0 → reg0=0x22.
- Reset mid-read: assert `reset` while driving a 0 data bit → next clk `sda_oe`=0, state IDLE, regs=0; a following 0x84 write transaction works normally.
- Pointer wrap: write pointer 0x03, then data 0x01, 0x02 → reg3=0x01, reg0=0x02.
